pipeline_hazard_ctrl: RTL and testbench

//  Sequences the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage core.

---
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline: stage-register loads, bubbles, forwarding selects.
// Build option: define FWD_EN to build the forwarding unit (only load-use hazards then stall).
module pipeline_hazard_ctrl #(
  parameter int RW          = 5,
  parameter int CNT_W       = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_wr,
  input  logic             ex_mem_rd,
  input  logic [RW-1:0]    mem_rd,
  input  logic             mem_wr,
  input  logic [RW-1:0]    wb_rd,
  input  logic             wb_wr,
  input  logic [RW-1:0]    ex_rs1,
  input  logic [RW-1:0]    ex_rs2,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stall_clr,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             ifid_flush,
  output logic             idex_load,
  output logic             idex_flush,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [RW-1:0] id_src [2];
  logic [RW-1:0] ex_src [2];
  logic [1:0]    id_use;
  logic [1:0]    src_hit;
  logic [1:0]    fwd_sel [2];
  logic          hz;

  assign id_src[0] = id_rs1;
  assign id_src[1] = id_rs2;
  assign ex_src[0] = ex_rs1;
  assign ex_src[1] = ex_rs2;
  assign id_use    = {id_use2, id_use1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef FWD_EN
      // With forwarding only a load in EX cannot supply its result in time.
      assign src_hit[gi] = id_use[gi] && (id_src[gi] != '0) &&
                           ex_wr && ex_mem_rd && (id_src[gi] == ex_rd);

      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (ex_src[gi] != '0) begin
          if (mem_wr && (mem_rd == ex_src[gi]))
            fwd_sel[gi] = 2'b10;
          else if (wb_wr && (wb_rd == ex_src[gi]))
            fwd_sel[gi] = 2'b01;
        end
      end
`else
      // Without forwarding ID waits until the producer sits in WB (regfile write-before-read).
      assign src_hit[gi] = id_use[gi] && (id_src[gi] != '0) &&
                           ((ex_wr && (id_src[gi] == ex_rd)) ||
                            (mem_wr && (id_src[gi] == mem_rd)));
      assign fwd_sel[gi] = 2'b00;
`endif
    end
  endgenerate

`ifndef FWD_EN
  logic unused_inputs;
  assign unused_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_wr, ex_mem_rd, ex_src[0], ex_src[1]};
`endif

  assign hz = |src_hit;

  logic ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb;
  logic fl_ifid, fl_idex;

  always_comb begin
    state_d  = state_q;
    ld_pc    = 1'b0;
    ld_ifid  = 1'b0;
    ld_idex  = 1'b0;
    ld_exmem = 1'b0;
    ld_memwb = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_d = MEM_WAIT;
          end else if (br_taken) begin
            ld_pc    = 1'b1;
            ld_ifid  = 1'b1;
            ld_idex  = 1'b1;
            ld_exmem = 1'b1;
            ld_memwb = 1'b1;
            fl_ifid  = 1'b1;
            fl_idex  = (FLUSH_DEPTH == 2);
          end else if (hz) begin
            ld_idex  = 1'b1;
            ld_exmem = 1'b1;
            ld_memwb = 1'b1;
            fl_idex  = 1'b1;
          end else begin
            ld_pc    = 1'b1;
            ld_ifid  = 1'b1;
            ld_idex  = 1'b1;
            ld_exmem = 1'b1;
            ld_memwb = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            ld_pc    = 1'b1;
            ld_ifid  = 1'b1;
            ld_idex  = 1'b1;
            ld_exmem = 1'b1;
            ld_memwb = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_load    = ld_pc;
  assign ifid_load  = ld_ifid;
  assign idex_load  = ld_idex;
  assign exmem_load = ld_exmem;
  assign memwb_load = ld_memwb;
  assign ifid_flush = fl_ifid & ld_ifid;
  assign idex_flush = fl_idex & ld_idex;
  assign fwd_a      = rst_n ? fwd_sel[0] : 2'b00;
  assign fwd_b      = rst_n ? fwd_sel[1] : 2'b00;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_clr)
      stall_count_d = '0;
    else if (!ld_pc && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench with a behavioural model plus directed literal checks for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic id_use1, id_use2, ex_wr, ex_mem_rd, mem_wr, wb_wr;
  logic br_taken, mem_req, mem_ready, stall_clr;

  logic pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load, memwb_load;
  logic [1:0] fwd_a, fwd_b, state;
  logic [15:0] stall_count;

  logic pc_load_1, ifid_load_1, ifid_flush_1, idex_load_1, idex_flush_1, exmem_load_1, memwb_load_1;
  logic [1:0] fwd_a_1, fwd_b_1, state_1;
  logic [3:0] stall_count_1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_mem_rd(ex_mem_rd),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_clr(stall_clr),
    .pc_load(pc_load), .ifid_load(ifid_load), .ifid_flush(ifid_flush),
    .idex_load(idex_load), .idex_flush(idex_flush), .exmem_load(exmem_load),
    .memwb_load(memwb_load), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.RW(5), .CNT_W(4), .FLUSH_DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_mem_rd(ex_mem_rd),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_clr(stall_clr),
    .pc_load(pc_load_1), .ifid_load(ifid_load_1), .ifid_flush(ifid_flush_1),
    .idex_load(idex_load_1), .idex_flush(idex_flush_1), .exmem_load(exmem_load_1),
    .memwb_load(memwb_load_1), .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .state(state_1),
    .stall_count(stall_count_1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode = 0;        // 0 running, 1 waiting on data memory
  int          m_mode_nxt = 0;
  logic [15:0] m_cnt = '0, m_cnt_nxt = '0;
  logic [3:0]  m_cnt1 = '0, m_cnt1_nxt = '0;

  // A source is blocked if a producer whose value cannot yet reach ID writes it.
  function automatic logic model_hz();
    logic [4:0] blocked[$];
    logic [4:0] srcs[$];
`ifdef FWD_EN
    if (ex_wr && ex_mem_rd) blocked.push_back(ex_rd);
`else
    if (ex_wr)  blocked.push_back(ex_rd);
    if (mem_wr) blocked.push_back(mem_rd);
`endif
    if (id_use1) srcs.push_back(id_rs1);
    if (id_use2) srcs.push_back(id_rs2);
    foreach (srcs[i])
      foreach (blocked[j])
        if (srcs[i] != 0 && srcs[i] == blocked[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Youngest older producer wins; codes per producer stage.
  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef FWD_EN
    logic       wr[2];
    logic [4:0] rd[2];
    logic [1:0] code[2];
    wr[0] = mem_wr; rd[0] = mem_rd; code[0] = 2'b10;
    wr[1] = wb_wr;  rd[1] = wb_rd;  code[1] = 2'b01;
    if (src == 0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (wr[k] && rd[k] == src) return code[k];
    return 2'b00;
`else
    return (src == 5'd31 && 1'b0) ? 2'b11 : 2'b00;
`endif
  endfunction

  always @(negedge clk) begin
    int   kind;  // 0 hold, 1 go, 2 branch, 3 hazard bubble
    logic e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_idexf1, e_exmem, e_memwb;
    logic [1:0] e_fa, e_fb;
    kind = 0;
    e_fa = 2'b00; e_fb = 2'b00;
    if (!rst_n) begin
      m_mode_nxt = 0;
    end else begin
      if (m_mode == 0) begin
        if (mem_req && !mem_ready) begin kind = 0; m_mode_nxt = 1; end
        else begin
          m_mode_nxt = 0;
          if (br_taken) kind = 2;
          else if (model_hz()) kind = 3;
          else kind = 1;
        end
      end else begin
        kind = mem_ready ? 1 : 0;
        m_mode_nxt = mem_ready ? 0 : 1;
      end
      e_fa = model_fwd(ex_rs1);
      e_fb = model_fwd(ex_rs2);
    end
    e_pc     = rst_n && (kind == 1 || kind == 2);
    e_ifid   = e_pc;
    e_idex   = rst_n && kind != 0;
    e_exmem  = e_idex;
    e_memwb  = e_idex;
    e_ifidf  = rst_n && kind == 2;
    e_idexf  = rst_n && (kind == 2 || kind == 3);
    e_idexf1 = rst_n && kind == 3;

    chk("m_loads", {pc_load, ifid_load, idex_load, exmem_load, memwb_load},
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb});
    chk("m_flush", {ifid_flush, idex_flush}, {e_ifidf, e_idexf});
    chk("m_fwd", {fwd_a, fwd_b}, {e_fa, e_fb});
    chk("m_state", state, m_mode[1:0]);
    chk("m_count", stall_count, m_cnt);
    chk("m1_loads", {pc_load_1, ifid_load_1, idex_load_1, exmem_load_1, memwb_load_1},
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb});
    chk("m1_flush", {ifid_flush_1, idex_flush_1}, {e_ifidf, e_idexf1});
    chk("m1_count", stall_count_1, m_cnt1);

    if (!rst_n || stall_clr) begin
      m_cnt_nxt = '0; m_cnt1_nxt = '0;
    end else begin
      m_cnt_nxt  = (!e_pc && m_cnt  != 16'hFFFF) ? m_cnt  + 16'd1 : m_cnt;
      m_cnt1_nxt = (!e_pc && m_cnt1 != 4'hF)     ? m_cnt1 + 4'd1  : m_cnt1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = '0; m_cnt1 = '0;
    end else begin
      m_mode = m_mode_nxt; m_cnt = m_cnt_nxt; m_cnt1 = m_cnt1_nxt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
    ex_rd = 0; ex_wr = 0; ex_mem_rd = 0; mem_rd = 0; mem_wr = 0;
    wb_rd = 0; wb_wr = 0; ex_rs1 = 0; ex_rs2 = 0;
    br_taken = 0; mem_req = 0; mem_ready = 1; stall_clr = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_load", pc_load, 0);
    chk("rst_state", state, 0);
    chk("rst_count", stall_count, 0);
    tick(); rst_n = 1'b1; #1;
    chk("idle_go", {pc_load, memwb_load, idex_flush}, 3'b110);

`ifdef FWD_EN
    // load-use: one bubble
    tick(); ex_wr = 1; ex_mem_rd = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1; #1;
    chk("lu_stall", {pc_load, ifid_load, idex_load, idex_flush}, 4'b0011);
    tick(); ex_wr = 0; ex_mem_rd = 0; #1;
    chk("lu_release", {pc_load, ifid_load, idex_flush}, 3'b110);
    chk("lu_count", stall_count, 1);
`else
    // ALU producer: stall while it sits in EX and MEM
    tick(); ex_wr = 1; ex_rd = 7; id_rs1 = 7; id_use1 = 1; #1;
    chk("raw_ex", {pc_load, idex_flush}, 2'b01);
    tick(); ex_wr = 0; mem_wr = 1; mem_rd = 7; #1;
    chk("raw_mem", {pc_load, idex_flush}, 2'b01);
    tick(); mem_wr = 0; wb_wr = 1; wb_rd = 7; #1;
    chk("raw_wb", {pc_load, idex_flush}, 2'b10);
    chk("raw_count", stall_count, 2);
`endif

    tick(); idle(); mem_wr = 1; mem_rd = 3; wb_wr = 1; wb_rd = 3; ex_rs1 = 3; #1;
`ifdef FWD_EN
    chk("fwd_exmem", fwd_a, 2'b10);
`else
    chk("fwd_off", fwd_a, 2'b00);
`endif
    ex_rs1 = 0; #1;
    chk("fwd_x0", fwd_a, 2'b00);
    mem_wr = 0; ex_rs2 = 3; #1;
`ifdef FWD_EN
    chk("fwd_memwb", fwd_b, 2'b01);
`else
    chk("fwd_off_b", fwd_b, 2'b00);
`endif

    tick(); idle(); ex_wr = 1; ex_mem_rd = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1; br_taken = 1; #1;
    chk("br_hz", {pc_load, ifid_flush, idex_flush}, 3'b111);
    chk("br_depth1", {ifid_flush_1, idex_flush_1}, 2'b10);

    tick(); idle(); stall_clr = 1;
    tick(); stall_clr = 0; mem_req = 1; mem_ready = 0; #1;
    chk("mw_first", {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, 5'b0);
    tick(); #1;
    chk("mw_state", state, 2'b01);
    chk("mw_loads", {pc_load, memwb_load}, 2'b00);
    tick(); #1;
    chk("mw_loads2", {pc_load, memwb_load}, 2'b00);
    tick(); mem_ready = 1; #1;
    chk("mw_ready", {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, 5'b11111);
    chk("mw_count", stall_count, 3);
    tick(); idle(); #1;
    chk("mw_back", state, 2'b00);

    tick(); mem_req = 1; mem_ready = 0;
    tick(); #1;
    chk("rst_mw_pre", state, 2'b01);
    rst_n = 1'b0; #1;
    chk("rst_mw_state", state, 2'b00);
    chk("rst_mw_out", {pc_load, memwb_load, idex_flush, fwd_a}, 5'b0);
    chk("rst_mw_cnt", stall_count, 0);
    tick(); rst_n = 1'b1; idle();

    tick(); mem_req = 1; mem_ready = 0;
    repeat (20) tick();
    chk("sat_count1", stall_count_1, 4'hF);
    chk("sat_count", stall_count, 20);
    stall_clr = 1;
    tick(); stall_clr = 0; #1;
    chk("clr_count", stall_count, 0);
    chk("clr_count1", stall_count_1, 0);
    tick(); idle();

    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        continue;
      end
      rst_n     = 1'b1;
      id_rs1    = 5'($urandom_range(0, 3));
      id_rs2    = 5'($urandom_range(0, 3));
      id_use1   = 1'($urandom);
      id_use2   = 1'($urandom);
      ex_rd     = 5'($urandom_range(0, 3));
      ex_wr     = 1'($urandom);
      ex_mem_rd = 1'($urandom);
      mem_rd    = 5'($urandom_range(0, 3));
      mem_wr    = 1'($urandom);
      wb_rd     = 5'($urandom_range(0, 3));
      wb_wr     = 1'($urandom);
      ex_rs1    = 5'($urandom_range(0, 3));
      ex_rs2    = 5'($urandom_range(0, 3));
      br_taken  = ($urandom_range(0, 7) == 0);
      mem_req   = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom);
      stall_clr = ($urandom_range(0, 31) == 0);
    end
    tick(); idle(); rst_n = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
